// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: LC-3 MAR/MDR + sync RAM with wait states, ready handshake and optional round-robin debug port
//   params : DATA_W word width, ADDR_W MAR/debug address width, MEM_AW RAM index width, WAIT_CYCLES extra wait cycles (0..15)
//   clk, reset (async, active-high)
//   cpu    : bus_in, ld_mar, ld_mdr, rd_req, wr_req -> mdr_out, mem_ready, busy
//   debug  : dbg_req, dbg_we, dbg_addr, dbg_wdata -> dbg_rdata, dbg_ack (present only with LC3_MEM_DEBUG_PORT_EN)
module lc3_mem_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int MEM_AW = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [DATA_W-1:0] mdr_out,
  output logic              mem_ready,
  output logic              busy,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack
);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACCESS = 2'd2;
  logic [1:0] state, nxt;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr, wdata;
  logic [MEM_AW-1:0] idx;
  logic we, own_dbg, cpu_req, dbg_sel, grant;
  logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];
  logic unused_bits;
  assign unused_bits = ^{dbg_req, mar, dbg_addr};
  assign cpu_req = rd_req | wr_req;
  assign mdr_out = mdr;
`ifdef LC3_MEM_DEBUG_PORT_EN
  logic last_dbg;
  // debug wins a tie only when the CPU had the previous grant
  assign dbg_sel = dbg_req & (!cpu_req | !last_dbg);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      last_dbg <= 1'b1;
      dbg_ack <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= (state == S_ACCESS) & own_dbg;
      if (grant) last_dbg <= dbg_sel;
      if (state == S_ACCESS && own_dbg && !we) dbg_rdata <= mem[idx];
    end
`else
  assign dbg_sel = 1'b0;
  assign dbg_ack = 1'b0;
  assign dbg_rdata = '0;
`endif
  assign grant = (state == S_IDLE) & (cpu_req | dbg_sel);
  always_comb
    nxt = (state == S_IDLE) ? (grant ? ((WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS) : S_IDLE) :
          (state == S_WAIT) ? ((cnt == 4'd0) ? S_ACCESS : S_WAIT) : S_IDLE;
  // address and write data are captured at grant so MAR/MDR stay frozen for the access
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      mar <= '0;
      mdr <= '0;
      wdata <= '0;
      idx <= '0;
      we <= 1'b0;
      own_dbg <= 1'b0;
      busy <= 1'b0;
      mem_ready <= 1'b0;
    end else begin
      state <= nxt;
      busy <= nxt != S_IDLE;
      mem_ready <= (state == S_ACCESS) & !own_dbg;
      if (grant) begin
        cnt <= 4'(WAIT_CYCLES - 1);
        own_dbg <= dbg_sel;
        we <= dbg_sel ? dbg_we : wr_req;
        idx <= dbg_sel ? dbg_addr[MEM_AW-1:0] : mar[MEM_AW-1:0];
        wdata <= dbg_sel ? dbg_wdata : mdr;
      end else if (state == S_IDLE) begin
        if (ld_mar) mar <= ADDR_W'(bus_in);
        if (ld_mdr) mdr <= bus_in;
      end
      if (state == S_WAIT) cnt <= cnt - 4'd1;
      if (state == S_ACCESS && !own_dbg && !we) mdr <= mem[idx];
    end
  always_ff @(posedge clk)
    if (state == S_ACCESS && we) mem[idx] <= wdata;
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: scoreboard bench for lc3_mem_ctrl (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 back-to-back instance)
module tb_lc3_mem_ctrl;
  logic clk = 0, rst = 1;
  logic [15:0] bus = 0, dbg_addr = 0, dbg_wdata = 0;
  logic ld_mar = 0, ld_mdr = 0, rd = 0, wr = 0, dbg_req = 0, dbg_we = 0;
  logic [15:0] mdr_out, dbg_rdata;
  logic mem_ready, busy, dbg_ack;
  logic [15:0] bus0 = 0;
  logic ld_mar0 = 0, ld_mdr0 = 0, rd0 = 0, wr0 = 0;
  logic [15:0] mdr0, dbg_rdata0;
  logic rdy0, busy0, dbg_ack0;
  int n_cmp = 0, n_err = 0;
  logic [15:0] cq[$], dq[$], q0[$];
  logic [15:0] ref_mem [0:4095];
  logic [15:0] cur_mar = 0, dbg_hold = 0;
  bit exp_last_dbg = 1;

  lc3_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .MEM_AW(12), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .reset(rst), .bus_in(bus), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .rd_req(rd), .wr_req(wr),
    .mdr_out(mdr_out), .mem_ready(mem_ready), .busy(busy), .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack));

  lc3_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .MEM_AW(12), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(rst), .bus_in(bus0), .ld_mar(ld_mar0), .ld_mdr(ld_mdr0), .rd_req(rd0), .wr_req(wr0),
    .mdr_out(mdr0), .mem_ready(rdy0), .busy(busy0), .dbg_req(1'b0), .dbg_we(1'b0),
    .dbg_addr(16'h0), .dbg_wdata(16'h0), .dbg_rdata(dbg_rdata0), .dbg_ack(dbg_ack0));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_ready) begin
      check("ready_expected", 32'(cq.size() > 0), 1);
      if (cq.size() > 0) check("mdr_out", mdr_out, cq.pop_front());
    end
    if (dbg_ack) begin
      check("ack_expected", 32'(dq.size() > 0), 1);
      if (dq.size() > 0) check("dbg_rdata", dbg_rdata, dq.pop_front());
    end
    if (rdy0) begin
      check("ready0_expected", 32'(q0.size() > 0), 1);
      if (q0.size() > 0) check("mdr0", mdr0, q0.pop_front());
    end
  end

  task automatic cpu_op(input bit w, input logic [15:0] a, input logic [15:0] d, input bit set_mar, input bit mid_mar);
    int k;
    if (set_mar) begin
      ld_mar = 1; bus = a; cur_mar = a;
      @(negedge clk);
      ld_mar = 0;
    end
    ld_mdr = 1; bus = w ? d : 16'h0;
    @(negedge clk);
    ld_mdr = 0;
    if (w) ref_mem[cur_mar[11:0]] = d;
    cq.push_back(w ? d : ref_mem[cur_mar[11:0]]);
    wr = w; rd = !w; exp_last_dbg = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) check("busy_in_access", busy, 1);
      if (mid_mar && k == 1) begin ld_mar = 1; bus = 16'h1234; end
      if (mid_mar && k == 2) ld_mar = 0;
    end while (!mem_ready && k < 40);
    rd = 0; wr = 0;
    check("cpu_latency", k, 4);
    check("busy_after", busy, 0);
  endtask

  task automatic dbg_op(input bit w, input logic [15:0] a, input logic [15:0] d);
    int k;
    dbg_req = 1; dbg_we = w; dbg_addr = a; dbg_wdata = d;
    if (w) ref_mem[a[11:0]] = d;
    else dbg_hold = ref_mem[a[11:0]];
    dq.push_back(dbg_hold);
    exp_last_dbg = 1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!dbg_ack && k < 40);
    dbg_req = 0;
    check("dbg_latency", k, 4);
  endtask

  initial begin
    int k, acks;
    repeat (2) @(negedge clk);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_mdr", mdr_out, 0);
    check("rst_dbg_ack", dbg_ack, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    rst = 0;
    @(negedge clk);
    cpu_op(1, 16'h3000, 16'hBEEF, 1, 0);
    cpu_op(0, 16'h3000, 16'h0, 1, 0);
    cpu_op(1, 16'hF005, 16'h5A5A, 1, 0);
    cpu_op(0, 16'h0005, 16'h0, 1, 0);
    cpu_op(1, 16'h0010, 16'hAAAA, 1, 0);
    cpu_op(1, 16'h1234, 16'h7777, 1, 0);
    ld_mar = 1; bus = 16'h0010; cur_mar = 16'h0010;
    @(negedge clk);
    ld_mar = 0;
    cpu_op(0, 16'h0010, 16'h0, 0, 1);
    cpu_op(0, 16'h0010, 16'h0, 0, 0);
    // zero-wait instance: write, then a held read produces two accesses
    ld_mar0 = 1; bus0 = 16'h0040;
    @(negedge clk);
    ld_mar0 = 0; ld_mdr0 = 1; bus0 = 16'h4242;
    @(negedge clk);
    ld_mdr0 = 0; wr0 = 1; q0.push_back(16'h4242);
    k = 0;
    do begin @(negedge clk); k++; end while (!rdy0 && k < 40);
    wr0 = 0;
    check("w0_latency", k, 2);
    ld_mdr0 = 1; bus0 = 16'h0;
    @(negedge clk);
    ld_mdr0 = 0; rd0 = 1; q0.push_back(16'h4242);
    k = 0;
    do begin @(negedge clk); k++; end while (!rdy0 && k < 40);
    check("r0_latency", k, 2);
    q0.push_back(16'h4242);
    @(negedge clk);
    rd0 = 0;
    check("b2b_gap", rdy0, 0);
    @(negedge clk);
    check("b2b_second_ready", rdy0, 1);
    @(negedge clk);
    check("b2b_no_third", rdy0, 0);
    // reset during WAIT of a write must leave RAM untouched
    cpu_op(1, 16'h0020, 16'h1111, 1, 0);
    ld_mdr = 1; bus = 16'h2222;
    @(negedge clk);
    ld_mdr = 0; wr = 1;
    @(negedge clk);
    check("abort_busy_pre", busy, 1);
    wr = 0; rst = 1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_mdr", mdr_out, 0);
    rst = 0; cur_mar = 0; exp_last_dbg = 1; dbg_hold = 0;
    repeat (6) @(negedge clk);
    cpu_op(0, 16'h0020, 16'h0, 1, 0);
`ifdef LC3_MEM_DEBUG_PORT_EN
    dbg_op(0, 16'h0020, 16'h0);
    dbg_op(1, 16'h0777, 16'hC0DE);
    dbg_op(0, 16'h0777, 16'h0);
    cpu_op(0, 16'h0777, 16'h0, 1, 0);
    begin
      bit first_dbg, want;
      int g;
      ld_mar = 1; bus = 16'h0005; cur_mar = 16'h0005;
      @(negedge clk);
      ld_mar = 0;
      first_dbg = !exp_last_dbg;
      repeat (2) begin cq.push_back(ref_mem[12'h005]); dq.push_back(ref_mem[12'h000]); end
      dbg_hold = ref_mem[12'h000];
      rd = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 16'h3000;
      g = 0; k = 0;
      while (g < 4 && k < 80) begin
        @(negedge clk);
        k++;
        if (mem_ready || dbg_ack) begin
          want = (g % 2 == 0) ? first_dbg : !first_dbg;
          check("rr_owner", dbg_ack, want);
          exp_last_dbg = dbg_ack;
          g++;
        end
      end
      rd = 0; dbg_req = 0;
      check("rr_grants", g, 4);
    end
`else
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0020;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      acks += int'(dbg_ack);
      if (busy) acks += 100;
    end
    dbg_req = 0;
    check("no_dbg_ack", acks, 0);
    check("dbg_rdata_zero", dbg_rdata, 0);
`endif
    repeat (8) @(negedge clk);
    check("cq_drained", cq.size(), 0);
    check("dq_drained", dq.size(), 0);
    check("q0_drained", q0.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
